fft_peak_detect: RTL and testbench

//  Streaming peak picker on FFT output bins, one bin per in_valid beat. Finds the two largest
//  |X[k]|^2 inside a programmable bin window and converts the winning bins to Hz. Sits between
//  the FFT core and the note-mapping logic, replacing single-peak decoding with gated top-2 output.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_mag_sq.sv | 57 +++++
 rtl/fft_peak_detect.sv | 188 ++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT peak detector: frame FSM states,
// default widths and the bin-to-frequency conversion.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} pk_state_t;

  localparam int BIT_WIDTH_DEF = 16;
  localparam int MAG_W_DEF     = 2 * BIT_WIDTH_DEF;

  // Bin index to Hz: (k * fs) >> n, truncated, clamped to 2**freq_w - 1.
  function automatic logic [31:0] freq_of_bin(input logic [31:0] k,
                                              input int unsigned fs,
                                              input int unsigned n,
                                              input int unsigned freq_w);
    logic [63:0] prod;
    logic [63:0] quot;
    logic [63:0] limit;
    prod  = 64'(k) * 64'(fs);
    quot  = prod >> n;
    limit = (64'd1 << freq_w) - 64'd1;
    if (quot > limit) quot = limit;
    return quot[31:0];
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Registered |X|^2 of one complex bin with saturation; the bin index and
// valid flag ride alongside so the result arrives one cycle later as a unit.
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int MAG_W     = MAG_W_DEF,
  parameter int N         = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_k,
  input  logic [2*BIT_WIDTH-1:0] fft_result,
  output logic                   out_valid,
  output logic [N-1:0]           out_k,
  output logic [MAG_W-1:0]       out_mag
);

  localparam logic signed [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic signed [BIT_WIDTH-1:0] re;
  logic signed [BIT_WIDTH-1:0] im;
  logic signed [MAG_W-1:0]     re_sq;
  logic signed [MAG_W-1:0]     im_sq;
  logic [MAG_W:0]              sum;
  logic                        sat;
  logic [MAG_W-1:0]            mag;

  // Squares and saturating sum; a most-negative component pins the result to all-ones.
  always_comb begin
    re    = fft_result[2*BIT_WIDTH-1:BIT_WIDTH];
    im    = fft_result[BIT_WIDTH-1:0];
    re_sq = re * re;
    im_sq = im * im;
    sum   = {1'b0, re_sq} + {1'b0, im_sq};
    sat   = (re == MOST_NEG) || (im == MOST_NEG) || sum[MAG_W];
    mag   = sat ? '1 : sum[MAG_W-1:0];
  end

  // Pipeline register for magnitude plus its sideband.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: data registers are reset as well, so no stale magnitude can ever
      // pair with a freshly cleared valid bit after reset.
      out_valid <= 1'b0;
      out_k     <= '0;
      out_mag   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      out_k     <= in_k;
      out_mag   <= mag;
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming top-2 peak picker over one FFT frame. Bins arrive one per
// in_valid beat; the two largest |X|^2 inside the sampled window are tracked,
// snapshotted when the last bin leaves the magnitude stage, and reported as Hz.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512,
  parameter int FS        = 48000,
  parameter int FREQ_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic [2*BIT_WIDTH-1:0] fft_result,
  input  logic [N-1:0]           k_lo,
  input  logic [N-1:0]           k_hi,
  input  logic [2*BIT_WIDTH-1:0] threshold,
  output logic                   result_valid,
  output logic                   note_present,
  output logic [FREQ_W-1:0]      freq1,
  output logic [FREQ_W-1:0]      freq2,
  output logic [2*BIT_WIDTH-1:0] mag1,
  output logic                   frame_abort
);

  localparam int           MAG_W    = 2 * BIT_WIDTH;
  localparam logic [N-1:0] LAST_BIN = N'(FFT_SIZE - 1);

  pk_state_t        state;
  logic             drain_cnt;
  logic [N-1:0]     k_cnt;
  logic [N-1:0]     bin_idx;
  logic             start;
  logic             accept;
  logic             last_in;
  logic [N-1:0]     win_lo;
  logic [N-1:0]     win_hi;
  logic [MAG_W-1:0] thr_r;

  logic             p_valid;
  logic [N-1:0]     p_k;
  logic [MAG_W-1:0] p_mag;
  logic             p_last;
  logic             in_win;

  logic [MAG_W-1:0] max1, max2, nxt_max1, nxt_max2;
  logic [N-1:0]     k1, k2, nxt_k1, nxt_k2;

  logic [MAG_W-1:0] s_max1, s_max2, s_thr;
  logic [N-1:0]     s_k1, s_k2;
  logic             rpt1, rpt2;

  // in_first is always taken (new frame, or abort of a partial one); plain
  // beats only count while a frame is being accumulated.
  assign start   = in_valid & in_first;
  assign accept  = start | (in_valid & (state == ACCUM));
  assign bin_idx = start ? '0 : k_cnt;
  assign last_in = accept & (bin_idx == LAST_BIN);
  assign p_last  = p_valid & (p_k == LAST_BIN);

  fft_mag_sq #(
    .BIT_WIDTH (BIT_WIDTH),
    .MAG_W     (MAG_W),
    .N         (N)
  ) u_mag (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (accept),
    .in_k       (bin_idx),
    .fft_result (fft_result),
    .out_valid  (p_valid),
    .out_k      (p_k),
    .out_mag    (p_mag)
  );

  // Frame FSM, bin counter, per-frame configuration capture and abort pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drain_cnt   <= 1'b0;
      k_cnt       <= '0;
      win_lo      <= '0;
      win_hi      <= '0;
      thr_r       <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= start && (state == ACCUM);
      if (accept) k_cnt <= bin_idx + 1'b1;
      if (start) begin
        win_lo <= k_lo;
        win_hi <= k_hi;
        thr_r  <= threshold;
      end
      case (state)
        IDLE:    if (start) state <= ACCUM;
        ACCUM:   if (!start && last_in) begin
                   state     <= DRAIN;
                   drain_cnt <= 1'b0;
                 end
        DRAIN:   if (start)          state     <= ACCUM;
                 else if (drain_cnt) state     <= REPORT;
                 else                drain_cnt <= 1'b1;
        REPORT:  state <= start ? ACCUM : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Candidate top-2 after folding in the bin leaving the magnitude stage.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    nxt_max1 = max1;
    nxt_k1   = k1;
    nxt_max2 = max2;
    nxt_k2   = k2;
    in_win   = p_valid && (p_k >= win_lo) && (p_k <= win_hi);
    if (in_win) begin
      if (p_mag > max1) begin
        nxt_max2 = max1;
        nxt_k2   = k1;
        nxt_max1 = p_mag;
        nxt_k1   = p_k;
      end else if (p_mag > max2) begin
        nxt_max2 = p_mag;
        nxt_k2   = p_k;
      end
    end
  end

  // Peak registers; a new frame start discards whatever is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max1 <= '0;
      k1   <= '0;
      max2 <= '0;
      k2   <= '0;
    end else if (start) begin
      max1 <= '0;
      k1   <= '0;
      max2 <= '0;
      k2   <= '0;
    end else begin
      max1 <= nxt_max1;
      k1   <= nxt_k1;
      max2 <= nxt_max2;
      k2   <= nxt_k2;
    end
  end

  // Snapshot of the completed frame, then the delayed registered report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_max1       <= '0;
      s_k1         <= '0;
      s_max2       <= '0;
      s_k2         <= '0;
      s_thr        <= '0;
      rpt1         <= 1'b0;
      rpt2         <= 1'b0;
      result_valid <= 1'b0;
      note_present <= 1'b0;
      freq1        <= '0;
      freq2        <= '0;
      mag1         <= '0;
    end else begin
      rpt1         <= p_last;
      rpt2         <= rpt1;
      result_valid <= rpt2;
      if (p_last) begin
        s_max1 <= nxt_max1;
        s_k1   <= nxt_k1;
        s_max2 <= nxt_max2;
        s_k2   <= nxt_k2;
        s_thr  <= thr_r;
      end
      if (rpt2) begin
        note_present <= s_max1 > s_thr;
        mag1         <= s_max1;
        freq1        <= (s_max1 > s_thr) ? FREQ_W'(freq_of_bin(32'(s_k1), FS, N, FREQ_W)) : '0;
        freq2        <= (s_max2 > s_thr) ? FREQ_W'(freq_of_bin(32'(s_k2), FS, N, FREQ_W)) : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: directed table of frames, hand
// sequences for overlap/abort/reset, and random frames against a top-2 model.
module tb_fft_peak_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_first;
  logic [31:0] fft_result;
  logic [8:0]  k_lo;
  logic [8:0]  k_hi;
  logic [31:0] threshold;
  logic        result_valid;
  logic        note_present;
  logic [15:0] freq1;
  logic [15:0] freq2;
  logic [31:0] mag1;
  logic        frame_abort;

  fft_peak_detect #(
    .BIT_WIDTH (16),
    .N         (9),
    .FFT_SIZE  (512),
    .FS        (48000),
    .FREQ_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .fft_result   (fft_result),
    .k_lo         (k_lo),
    .k_hi         (k_hi),
    .threshold    (threshold),
    .result_valid (result_valid),
    .note_present (note_present),
    .freq1        (freq1),
    .freq2        (freq2),
    .mag1         (mag1),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        note;
    logic [15:0] f1;
    logic [15:0] f2;
    logic [31:0] m1;
  } res_t;

  typedef struct {
    int          ka, ra, ia;
    int          kb, rb, ib;
    int          kc, rc, ic;
    int          lo, hi;
    logic [31:0] thr;
    logic        note;
    int          f1, f2;
    logic [31:0] m1;
  } vec_t;

  int      fre[512];
  int      fim[512];
  res_t    res_q[$];
  int      ab_count;
  longint  cyc;
  longint  last_cyc;
  longint  rv_cyc;
  int      total;
  int      bad;

  always @(posedge clk) cyc++;

  // Collect every report and abort pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (result_valid) begin
      res_q.push_back('{note_present, freq1, freq2, mag1});
      rv_cyc = cyc;
    end
    if (frame_abort) ab_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint mag_of(int re, int im);
    longint m;
    if (re == -32768 || im == -32768) return 64'hFFFF_FFFF;
    m = longint'(re) * re + longint'(im) * im;
    if (m > 64'hFFFF_FFFF) m = 64'hFFFF_FFFF;
    return m;
  endfunction

  function automatic int hz(int k);
    longint q;
    q = (longint'(k) * 48000) >> 9;
    if (q > 65535) q = 65535;
    return int'(q);
  endfunction

  // Largest bin (lowest k on ties), then largest of the remaining bins.
  function automatic res_t model(int lo, int hi, logic [31:0] thr);
    longint m1 = 0, m2 = 0;
    int     k1 = -1, k2 = -1;
    res_t   r;
    for (int k = lo; k <= hi; k++)
      if (k1 < 0 || mag_of(fre[k], fim[k]) > m1) begin
        m1 = mag_of(fre[k], fim[k]);
        k1 = k;
      end
    for (int k = lo; k <= hi; k++)
      if (k != k1 && (k2 < 0 || mag_of(fre[k], fim[k]) > m2)) begin
        m2 = mag_of(fre[k], fim[k]);
        k2 = k;
      end
    r.note = m1 > longint'(thr);
    r.f1   = r.note ? 16'(hz(k1)) : 16'd0;
    r.f2   = (k2 >= 0 && m2 > longint'(thr)) ? 16'(hz(k2)) : 16'd0;
    r.m1   = m1[31:0];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_frame();
    for (int k = 0; k < 512; k++) begin
      fre[k] = 0;
      fim[k] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
    end
  endtask

  // Sends bins 0..nbins-1; configuration is only meaningful on the first beat.
  task automatic send_frame(input int nbins, input int lo, input int hi,
                            input logic [31:0] thr, input int gap_pct);
    for (int k = 0; k < nbins; k++) begin
      if (k != 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          @(negedge clk);
          in_valid   = 1'b0;
          in_first   = 1'($urandom_range(1));
          fft_result = $urandom;
        end
      end
      @(negedge clk);
      in_valid   = 1'b1;
      in_first   = (k == 0);
      fft_result = {16'(fre[k]), 16'(fim[k])};
      if (k == 0) begin
        k_lo      = 9'(lo);
        k_hi      = 9'(hi);
        threshold = thr;
      end else begin
        k_lo      = 9'($urandom);
        k_hi      = 9'($urandom);
        threshold = $urandom;
      end
      last_cyc = cyc + 1;
    end
  endtask

  task automatic check_res(input string tag, input res_t exp);
    res_t r;
    for (int t = 0; t < 40 && res_q.size() == 0; t++) @(negedge clk);
    check({tag, " present"}, 64'(res_q.size() != 0), 64'd1);
    if (res_q.size() == 0) return;
    r = res_q.pop_front();
    check({tag, " note_present"}, 64'(r.note), 64'(exp.note));
    check({tag, " freq1"},        64'(r.f1),   64'(exp.f1));
    check({tag, " freq2"},        64'(r.f2),   64'(exp.f2));
    check({tag, " mag1"},         64'(r.m1),   64'(exp.m1));
  endtask

  // Single isolated frame: result, latency and no duplicate report.
  task automatic single_frame(input string tag, input int lo, input int hi,
                              input logic [31:0] thr, input int gap_pct, input res_t exp);
    send_frame(512, lo, hi, thr, gap_pct);
    idle(8);
    check_res(tag, exp);
    check({tag, " latency"}, 64'(rv_cyc - last_cyc), 64'd3);
    check({tag, " single"}, 64'(res_q.size()), 64'd0);
  endtask

  vec_t vecs[8];
  res_t exp_a;
  res_t exp_b;

  initial begin
    total = 0; bad = 0; ab_count = 0; cyc = 0; last_cyc = 0; rv_cyc = 0;
    reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; fft_result = '0;
    k_lo = '0; k_hi = '0; threshold = '0;

    vecs[0] = '{43, 1000, 0,   -1, 0, 0,      -1, 0, 0,    2, 255, 32'd20000, 1'b1, 4031,  0,    32'd1000000};
    vecs[1] = '{20, 800, 600,  60, 300, 400,  -1, 0, 0,    2, 255, 32'd20000, 1'b1, 1875,  5625, 32'd1000000};
    vecs[2] = '{30, 500, 0,    90, 500, 0,    -1, 0, 0,    2, 255, 32'd20000, 1'b1, 2812,  8437, 32'd250000};
    vecs[3] = '{1, 1000, 0,    50, 100, 0,    70, 120, 0,  2, 255, 32'd20000, 1'b0, 0,     0,    32'd14400};
    vecs[4] = '{1, 1000, 0,    50, 100, 0,    70, 120, 0,  10, 5,  32'd20000, 1'b0, 0,     0,    32'd0};
    vecs[5] = '{2, 300, 0,     255, 400, 0,   256, 1000, 0, 2, 255, 32'd20000, 1'b1, 23906, 187,  32'd160000};
    vecs[6] = '{100, 200, 0,   -1, 0, 0,      -1, 0, 0,    0, 511, 32'd40000, 1'b0, 0,     0,    32'd40000};
    vecs[7] = '{511, 1000, 0,  1, 0, -700,    -1, 0, 0,    0, 511, 32'd20000, 1'b1, 47906, 93,   32'd1000000};

    repeat (3) @(negedge clk);
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset note_present", 64'(note_present), 64'd0);
    check("reset freq1",        64'(freq1),        64'd0);
    check("reset freq2",        64'(freq2),        64'd0);
    check("reset mag1",         64'(mag1),         64'd0);
    check("reset frame_abort",  64'(frame_abort),  64'd0);
    reset = 1'b1;
    idle(2);

    // in_valid without in_first while idle must not start a frame.
    clear_frame();
    fre[5] = 3000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_first = 1'b0; fft_result = 32'h0BB8_0000;
    end
    idle(8);
    check("idle stray beats", 64'(res_q.size()), 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      res_t e;
      clear_frame();
      if (vecs[i].ka >= 0) begin fre[vecs[i].ka] = vecs[i].ra; fim[vecs[i].ka] = vecs[i].ia; end
      if (vecs[i].kb >= 0) begin fre[vecs[i].kb] = vecs[i].rb; fim[vecs[i].kb] = vecs[i].ib; end
      if (vecs[i].kc >= 0) begin fre[vecs[i].kc] = vecs[i].rc; fim[vecs[i].kc] = vecs[i].ic; end
      e = '{vecs[i].note, 16'(vecs[i].f1), 16'(vecs[i].f2), vecs[i].m1};
      single_frame($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].thr, 0, e);
    end

    // Next frame starts while the previous one is draining.
    clear_frame();
    fre[43] = 1000;
    exp_a = model(2, 255, 32'd20000);
    send_frame(512, 2, 255, 32'd20000, 0);
    clear_frame();
    fre[43] = 1000; fre[100] = 600; fre[60] = 300; fim[60] = 400;
    exp_b = model(50, 120, 32'd100000);
    send_frame(512, 50, 120, 32'd100000, 0);
    idle(8);
    check_res("b2b first", exp_a);
    check_res("b2b second", exp_b);

    // Abort partway through a frame, without and with input gaps.
    for (int g = 0; g < 2; g++) begin
      res_t e;
      ab_count = 0;
      clear_frame();
      fre[150] = 2000;
      send_frame(200, 0, 511, 32'd0, g * 30);
      clear_frame();
      fre[43] = 1000; fre[300] = 500;
      e = model(2, 400, 32'd20000);
      single_frame($sformatf("abort gap%0d", g * 30), 2, 400, 32'd20000, g * 30, e);
      check($sformatf("abort gap%0d pulses", g * 30), 64'(ab_count), 64'd1);
    end

    // Reset mid-frame, then a full frame containing a saturating bin.
    clear_frame();
    fre[150] = 2000;
    send_frame(300, 0, 511, 32'd0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset result_valid", 64'(result_valid), 64'd0);
    check("midreset note_present", 64'(note_present), 64'd0);
    check("midreset freq1",        64'(freq1),        64'd0);
    check("midreset mag1",         64'(mag1),         64'd0);
    idle(2);
    reset = 1'b1;
    idle(2);
    begin
      res_t e;
      clear_frame();
      fre[77] = -32768; fim[77] = -32768; fre[200] = 1000;
      e = model(0, 511, 32'd20000);
      check("sat model mag", 64'(e.m1), 64'hFFFF_FFFF);
      single_frame("post reset sat", 0, 511, 32'd20000, 0, e);
    end

    // Random frames against the model.
    for (int n = 0; n < 6; n++) begin
      res_t        e;
      int          lo, hi, gap;
      logic [31:0] thr;
      for (int k = 0; k < 512; k++) begin
        fre[k] = int'($urandom_range(600)) - 300;
        fim[k] = int'($urandom_range(600)) - 300;
      end
      for (int t = 0; t < 3; t++) begin
        int kk = int'($urandom_range(511));
        fre[kk] = int'($urandom_range(40000)) - 20000;
        fim[kk] = int'($urandom_range(40000)) - 20000;
      end
      lo  = int'($urandom_range(511));
      hi  = (n == 5) ? int'($urandom_range(lo)) : int'($urandom_range(511, lo));
      thr = 32'($urandom_range(500000));
      gap = int'($urandom_range(40));
      e   = model(lo, hi, thr);
      single_frame($sformatf("rand%0d", n), lo, hi, thr, gap, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
